// File: rtl/nes_execution_controller.sv
// Run/halt/step sequencer producing the NES clock enable, with an opcode-fetch
// breakpoint and a count of enabled NES cycles.
module nes_execution_controller #(
  parameter bit RESET_RUNNING = 1'b0,
  parameter int CYCLE_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  input  logic [15:0]            i_step_count,
  output logic                   o_cmd_ready,
  input  logic                   i_bp_wr,
  input  logic                   i_bp_enable,
  input  logic [15:0]            i_bp_address,
  input  logic [15:0]            i_cpu_address,
  input  logic                   i_cpu_sync,
  input  logic                   i_cycle_clear,
  output logic                   o_ce,
  output logic                   o_halted,
  output logic [1:0]             o_state,
  output logic                   o_bp_hit,
  output logic [15:0]            o_steps_remaining,
  output logic [CYCLE_WIDTH-1:0] o_cycle_count
);

  localparam logic [1:0] HALTED   = 2'd0;
  localparam logic [1:0] RUNNING  = 2'd1;
  localparam logic [1:0] STEPPING = 2'd2;

  localparam logic [1:0] CMD_HALT = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;

  localparam logic [1:0] RESET_STATE = RESET_RUNNING ? RUNNING : HALTED;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic                   ce;
  logic                   bp_hit;
  logic                   bp_hit_next;
  logic [15:0]            steps;
  logic [15:0]            steps_next;
  logic                   bp_enable;
  logic [15:0]            bp_address;
  logic [CYCLE_WIDTH-1:0] cycle_count;
  logic                   cmd_accept;
  logic                   bp_match;

  // STEP 0 and the reserved code are treated as if no command arrived at all.
  assign cmd_accept = i_cmd_valid &&
                      ((i_cmd == CMD_HALT) || (i_cmd == CMD_RUN) ||
                       ((i_cmd == CMD_STEP) && (i_step_count != 16'd0)));

  assign bp_match = ce && i_cpu_sync && bp_enable && (i_cpu_address == bp_address);

  always_comb begin
    state_next  = state;
    bp_hit_next = bp_hit;
    steps_next  = steps;
    if (cmd_accept) begin
      case (i_cmd)
        CMD_HALT: begin
          state_next = HALTED;
          steps_next = 16'd0;
        end
        CMD_RUN: begin
          state_next  = RUNNING;
          bp_hit_next = 1'b0;
          steps_next  = 16'd0;
        end
        default: begin
          state_next  = STEPPING;
          bp_hit_next = 1'b0;
          steps_next  = i_step_count;
        end
      endcase
    end else if (bp_match) begin
      state_next  = HALTED;
      bp_hit_next = 1'b1;
      steps_next  = 16'd0;
    end else if ((state == STEPPING) && ce) begin
      if (steps == 16'd1) begin
        state_next = HALTED;
        steps_next = 16'd0;
      end else begin
        steps_next = steps - 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= RESET_STATE;
      ce          <= RESET_RUNNING;
      bp_hit      <= 1'b0;
      steps       <= 16'd0;
      bp_enable   <= 1'b0;
      bp_address  <= 16'd0;
      cycle_count <= '0;
    end else begin
      state  <= state_next;
      // ce is registered from the next state so it always mirrors the state register.
      ce     <= (state_next != HALTED);
      bp_hit <= bp_hit_next;
      steps  <= steps_next;
      if (i_bp_wr) begin
        bp_enable  <= i_bp_enable;
        bp_address <= i_bp_address;
      end
      if (i_cycle_clear) begin
        cycle_count <= '0;
      end else if (ce) begin
        cycle_count <= cycle_count + 1'b1;
      end
    end
  end

  assign o_cmd_ready       = ~i_reset;
  assign o_ce              = ce;
  assign o_halted          = (state == HALTED);
  assign o_state           = state;
  assign o_bp_hit          = bp_hit;
  assign o_steps_remaining = steps;
  assign o_cycle_count     = cycle_count;

endmodule

// File: tb/tb_nes_execution_controller.sv
// Directed bench for nes_execution_controller: a default instance plus a
// RESET_RUNNING=1, 4-bit counter instance for wrap-around.
module tb_nes_execution_controller;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, bp_wr, bp_enable, cpu_sync, cycle_clear;
  logic [1:0]  cmd;
  logic [15:0] step_count, bp_address, cpu_address;
  logic        cmd_ready, ce, halted, bp_hit;
  logic [1:0]  state;
  logic [15:0] steps;
  logic [31:0] cycle_count;

  logic        rst2, clr2;
  logic        ready2, ce2, halted2, hit2;
  logic [1:0]  state2;
  logic [15:0] steps2;
  logic [3:0]  count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nes_execution_controller dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_step_count(step_count), .o_cmd_ready(cmd_ready), .i_bp_wr(bp_wr),
    .i_bp_enable(bp_enable), .i_bp_address(bp_address), .i_cpu_address(cpu_address),
    .i_cpu_sync(cpu_sync), .i_cycle_clear(cycle_clear), .o_ce(ce), .o_halted(halted),
    .o_state(state), .o_bp_hit(bp_hit), .o_steps_remaining(steps),
    .o_cycle_count(cycle_count)
  );

  nes_execution_controller #(.RESET_RUNNING(1'b1), .CYCLE_WIDTH(4)) dut2 (
    .i_clk(clk), .i_reset(rst2), .i_cmd_valid(1'b0), .i_cmd(2'd0),
    .i_step_count(16'd0), .o_cmd_ready(ready2), .i_bp_wr(1'b0),
    .i_bp_enable(1'b0), .i_bp_address(16'd0), .i_cpu_address(16'd0),
    .i_cpu_sync(1'b0), .i_cycle_clear(clr2), .o_ce(ce2), .o_halted(halted2),
    .o_state(state2), .o_bp_hit(hit2), .o_steps_remaining(steps2),
    .o_cycle_count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] n);
    cmd_valid = 1'b1; cmd = op; step_count = n;
    tick();
    cmd_valid = 1'b0; step_count = 16'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    cmd_valid = 0; cmd = 0; step_count = 0; bp_wr = 0; bp_enable = 0;
    bp_address = 0; cpu_address = 0; cpu_sync = 0; cycle_clear = 0; clr2 = 0;
    tick(); tick();
    checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", ce); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cmd_ready); end
    checks++; if ({halted, bp_hit, steps} !== {1'b1, 1'b0, 16'd0}) begin errors++;
      $display("FAIL reset_flags got %b/%b/%0d exp 1/0/0", halted, bp_hit, steps); end
    checks++; if ({ce2, state2, ready2} !== {1'b1, 2'd1, 1'b0}) begin errors++;
      $display("FAIL reset_running got ce=%b st=%0d rdy=%b exp 1/1/0", ce2, state2, ready2); end
    rst = 1'b0; rst2 = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", cmd_ready); end
    tick();
    checks++; if ({ce, cycle_count} !== {1'b0, 32'd0}) begin errors++;
      $display("FAIL idle_halted got ce=%b cnt=%0d exp 0/0", ce, cycle_count); end
  endtask

  task automatic test_step5();
    issue(2'd2, 16'd5);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({ce, steps} !== {1'b1, 16'(5 - i)}) begin errors++;
        $display("FAIL step5_cycle%0d got ce=%b rem=%0d exp 1/%0d", i, ce, steps, 5 - i); end
      tick();
    end
    checks++; if ({ce, steps, halted} !== {1'b0, 16'd0, 1'b1}) begin errors++;
      $display("FAIL step5_end got ce=%b rem=%0d h=%b exp 0/0/1", ce, steps, halted); end
    checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL step5_count got %0d exp 5", cycle_count); end
  endtask

  task automatic test_breakpoint();
    bp_wr = 1'b1; bp_enable = 1'b1; bp_address = 16'hC004;
    tick();
    bp_wr = 1'b0;
    issue(2'd1, 16'd0);
    cpu_sync = 1'b1; cpu_address = 16'hC000;
    tick();
    checks++; if ({ce, bp_hit} !== {1'b1, 1'b0}) begin errors++;
      $display("FAIL bp_nomatch got ce=%b hit=%b exp 1/0", ce, bp_hit); end
    cpu_address = 16'hC004;
    #1;
    checks++; if (ce !== 1'b1) begin errors++; $display("FAIL bp_match_cycle_ce got %b exp 1", ce); end
    tick();
    cpu_sync = 1'b0;
    checks++; if ({ce, bp_hit, state} !== {1'b0, 1'b1, 2'd0}) begin errors++;
      $display("FAIL bp_halt got ce=%b hit=%b st=%0d exp 0/1/0", ce, bp_hit, state); end
    issue(2'd1, 16'd0);
    checks++; if ({ce, bp_hit, state} !== {1'b1, 1'b0, 2'd1}) begin errors++;
      $display("FAIL bp_resume got ce=%b hit=%b st=%0d exp 1/0/1", ce, bp_hit, state); end
  endtask

  task automatic test_simultaneous();
    cpu_sync = 1'b1; cpu_address = 16'hC004;
    issue(2'd1, 16'd0);
    checks++; if ({state, bp_hit, ce} !== {2'd1, 1'b0, 1'b1}) begin errors++;
      $display("FAIL run_vs_match got st=%0d hit=%b ce=%b exp 1/0/1", state, bp_hit, ce); end
    issue(2'd0, 16'd0);
    cpu_sync = 1'b0;
    checks++; if ({state, bp_hit, ce} !== {2'd0, 1'b0, 1'b0}) begin errors++;
      $display("FAIL halt_vs_match got st=%0d hit=%b ce=%b exp 0/0/0", state, bp_hit, ce); end
    // Breakpoint rewritten while the old address is on the bus: old value still matches.
    issue(2'd1, 16'd0);
    bp_wr = 1'b1; bp_address = 16'h1234; cpu_sync = 1'b1; cpu_address = 16'hC004;
    tick();
    bp_wr = 1'b0; cpu_sync = 1'b0;
    checks++; if ({state, bp_hit} !== {2'd0, 1'b1}) begin errors++;
      $display("FAIL bp_write_old got st=%0d hit=%b exp 0/1", state, bp_hit); end
    issue(2'd2, 16'd10);
    cpu_sync = 1'b1; cpu_address = 16'h1234;
    tick();
    cpu_sync = 1'b0;
    checks++; if ({state, bp_hit, steps} !== {2'd0, 1'b1, 16'd0}) begin errors++;
      $display("FAIL bp_in_step got st=%0d hit=%b rem=%0d exp 0/1/0", state, bp_hit, steps); end
  endtask

  task automatic test_step_reload();
    int          n;
    logic [31:0] start;
    n = 0;
    start = cycle_count;
    issue(2'd2, 16'd10);
    checks++; if ({state, steps, bp_hit} !== {2'd2, 16'd10, 1'b0}) begin errors++;
      $display("FAIL step10_start got st=%0d rem=%0d hit=%b exp 2/10/0", state, steps, bp_hit); end
    repeat (3) begin
      if (ce) n++;
      tick();
    end
    cmd_valid = 1'b1; cmd = 2'd2; step_count = 16'd3;
    if (ce) n++;
    tick();
    cmd_valid = 1'b0; step_count = 16'd0;
    checks++; if (steps !== 16'd3) begin errors++; $display("FAIL reload_rem got %0d exp 3", steps); end
    repeat (10) begin
      if (ce) n++;
      tick();
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL reload_total got %0d exp 7", n); end
    checks++; if (cycle_count - start !== 32'd7) begin errors++;
      $display("FAIL reload_count got %0d exp 7", cycle_count - start); end
    start = cycle_count;
    issue(2'd2, 16'd0);
    checks++; if ({state, ce, steps, cycle_count} !== {2'd0, 1'b0, 16'd0, start}) begin errors++;
      $display("FAIL step0 got st=%0d ce=%b rem=%0d cnt=%0d exp 0/0/0/%0d", state, ce, steps, cycle_count, start); end
    issue(2'd3, 16'd5);
    checks++; if ({state, ce, steps} !== {2'd0, 1'b0, 16'd0}) begin errors++;
      $display("FAIL reserved_halted got st=%0d ce=%b rem=%0d exp 0/0/0", state, ce, steps); end
    issue(2'd1, 16'd0);
    issue(2'd3, 16'd5);
    checks++; if ({state, ce, steps} !== {2'd1, 1'b1, 16'd0}) begin errors++;
      $display("FAIL reserved_running got st=%0d ce=%b rem=%0d exp 1/1/0", state, ce, steps); end
  endtask

  task automatic test_counter();
    tick(); tick();
    cycle_clear = 1'b1;
    tick();
    cycle_clear = 1'b0;
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL clear got %0d exp 0", cycle_count); end
    tick(); tick();
    checks++; if (cycle_count !== 32'd2) begin errors++; $display("FAIL clear_resume got %0d exp 2", cycle_count); end
    issue(2'd0, 16'd0);
    rst2 = 1'b1;
    #1;
    rst2 = 1'b0;
    repeat (15) tick();
    checks++; if (count2 !== 4'hF) begin errors++; $display("FAIL wrap_full got %h exp f", count2); end
    tick();
    checks++; if (count2 !== 4'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", count2); end
    tick();
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    checks++; if ({count2, ce2, state2} !== {4'h0, 1'b1, 2'd1}) begin errors++;
      $display("FAIL clear4 got cnt=%h ce=%b st=%0d exp 0/1/1", count2, ce2, state2); end
  endtask

  initial begin
    test_reset();
    test_step5();
    test_breakpoint();
    test_simultaneous();
    test_step_reload();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_execution_controller.md
# nes_execution_controller

Run/halt/step sequencer for the NES core, driven by the debugger. It produces the NES clock-enable (`o_ce`) in the 5 MHz NES clock domain. It executes RUN, HALT and STEP-N-cycles commands, stops on a CPU opcode-fetch address breakpoint, and keeps a count of enabled NES cycles. It sits between the debugger value/command decode and the NES `i_ce` input.

## Interface
- `RESET_RUNNING`, default 0: state entered at reset; 0 = HALTED, 1 = RUNNING.
- `CYCLE_WIDTH`, default 32: width of the enabled-cycle counter.

Ports:
- `i_clk`, in, 1: NES clock (5 MHz); all logic is on its rising edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_cmd_valid`, in, 1: command strobe, single cycle.
- `i_cmd`, in, 2: 0 = HALT, 1 = RUN, 2 = STEP, 3 = reserved (ignored).
- `i_step_count`, in, 16: cycle count for STEP; sampled with `i_cmd_valid`.
- `o_cmd_ready`, out, 1: controller accepts commands.
- `i_bp_wr`, in, 1: load breakpoint registers.
- `i_bp_enable`, in, 1: breakpoint enable, loaded on `i_bp_wr`.
- `i_bp_address`, in, 16: breakpoint address, loaded on `i_bp_wr`.
- `i_cpu_address`, in, 16: CPU address bus.
- `i_cpu_sync`, in, 1: CPU opcode-fetch cycle indicator.
- `i_cycle_clear`, in, 1: clear the cycle counter.
- `o_ce`, out, 1: NES clock enable; registered.
- `o_halted`, out, 1: state is HALTED.
- `o_state`, out, 2: 0 = HALTED, 1 = RUNNING, 2 = STEPPING.
- `o_bp_hit`, out, 1: sticky flag, breakpoint caused the last halt.
- `o_steps_remaining`, out, 16: STEP cycles still to run.
- `o_cycle_count`, out, `CYCLE_WIDTH`: count of cycles with `o_ce` = 1.

## Operation
- **Reset values:**
  - state = HALTED, or RUNNING if `RESET_RUNNING` = 1.
  - `o_ce` = `RESET_RUNNING`.
  - `o_bp_hit` = 0, `o_steps_remaining` = 0, `o_cycle_count` = 0.
  - breakpoint enable = 0, breakpoint address = 0.
  - `o_cmd_ready` = 0 while `i_reset` is high; otherwise always 1.
- **States:** HALTED, RUNNING, STEPPING; `o_ce` = 1 exactly when the registered state is RUNNING or STEPPING.
- **HALT** (any state) -> HALTED. Clears `o_steps_remaining`. Does not change `o_bp_hit`.
- **RUN** (any state) -> RUNNING. Clears `o_bp_hit` and `o_steps_remaining`.
- **STEP N, N > 0** (any state) -> STEPPING with `o_steps_remaining` = N. Clears `o_bp_hit`. A STEP issued during STEPPING reloads the counter to N.
- **STEP 0** is a no-op: state, flags and counter are unchanged.
- **STEPPING:** each cycle with `o_ce` = 1 decrements `o_steps_remaining`. When the value is 1 at a ce cycle, the next state is HALTED and the counter becomes 0.
- **Breakpoint match:** `o_ce` = 1 AND `i_cpu_sync` AND breakpoint enabled AND `i_cpu_address` == breakpoint address, in RUNNING or STEPPING.
  - Next state = HALTED, `o_bp_hit` <= 1, `o_steps_remaining` <= 0.
  - No match is possible in HALTED, because `o_ce` = 0.
- **Priority, highest first:** valid command (`i_cmd_valid` with `i_cmd` 0-2), then breakpoint match, then step expiry. When a command coincides with a match, the command wins and `o_bp_hit` is not set by that match.
- **Breakpoint write:** `i_bp_wr` takes effect for comparisons from the next cycle. A match in the same cycle as the write uses the old breakpoint values.
- **Cycle counter:**
  - Increments in every cycle where `o_ce` = 1.
  - Wraps from all-ones to 0.
  - `i_cycle_clear` forces 0 and overrides an increment in the same cycle.
- Reserved command 3 is ignored entirely.

## Timing
- Command sampled at edge t takes effect at edge t: `o_ce` and `o_state` change from cycle t+1.
- STEP N issued at edge t gives `o_ce` = 1 for exactly cycles t+1 .. t+N; `o_ce` = 0 from t+N+1.
- The breakpoint match cycle keeps `o_ce` = 1, so the NES completes the fetch cycle. `o_ce` = 0 and `o_bp_hit` = 1 from the next cycle.
- Resuming with RUN after a breakpoint does not re-trigger, because the CPU has already advanced past the sync cycle.
- `o_halted` and `o_state` are derived from the state register; zero combinational path from inputs to outputs.
- Asserting `i_reset` mid-STEP immediately forces all reset values, asynchronously.

## Test plan
- **Reset:** assert `i_reset` with `RESET_RUNNING` = 0 -> `o_ce` = 0, `o_state` = 0, `o_cycle_count` = 0, `o_cmd_ready` = 0; release -> `o_cmd_ready` = 1.
- **STEP 5 from HALTED:** `o_ce` high for exactly 5 cycles; `o_steps_remaining` 5, 4, 3, 2, 1, then 0; `o_cycle_count` = 5; `o_halted` = 1 afterwards.
- **Breakpoint:** set bp = 0xC004, enabled; RUN; drive sync with address 0xC000 then 0xC004 -> `o_ce` = 0 on the cycle after the 0xC004 sync, `o_bp_hit` = 1. A subsequent RUN clears `o_bp_hit` and `o_ce` returns to 1.
- **Simultaneous command and match:** RUN issued in the same cycle as a bp match while RUNNING -> stays RUNNING, `o_bp_hit` = 0. HALT in the match cycle -> HALTED, `o_bp_hit` = 0.
- **STEP reload, STEP 0, reserved command:**
  - STEP 10, then STEP 3 after 4 cycles -> 7 total ce cycles.
  - STEP 0 while HALTED -> no change.
  - `i_cmd` = 3 -> no change.
- **Counter:** preload by running `o_cycle_count` to 0xFFFFFFFF (4-bit `CYCLE_WIDTH` instance: 0xF) -> wraps to 0. `i_cycle_clear` during RUNNING gives 0 that cycle and then resumes counting.
